maze_path_checker: RTL
======================

# maze_path_checker

Consumer end of the maze-solver link: receives a 17×17 maze in the same serial cell format the solver ingests, then consumes the solver's move stream. It tracks position and sword state, flags the first illegal move, and reports pass/fail, error code and step count. It sits opposite the solver in the maze subsystem and is reused as the on-chip self-check.

## Interface
- `N`, 17: maze side length in cells.
- `WAIT_MAX`, 5000: cycle limit between the last maze cell and the first move.
- `MAX_STEPS`, 10000: move limit per maze.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  maze cell valid; N·N contiguous cycles, row-major.
- `in`  in  2  cell code: 0 path, 1 wall, 2 sword, 3 monster.
- `mv_valid`  in  1  move valid; contiguous burst.
- `mv`  in  2  move: 0 right (col+1), 1 down (row+1), 2 left, 3 up.
- `done`  out  1  one-cycle result pulse.
- `pass`  out  1  valid with `done`; 1 = legal path reaching the goal.
- `err`  out  3  valid with `done`; error code, first error only.
- `steps`  out  14  valid with `done`; count of moves accepted before the error or the end.

## Operation
- Error codes:
  - 0 NONE.
  - 1 WALL: entered a wall cell.
  - 2 MONSTER: entered a monster cell without the sword.
  - 3 OOB: left the grid.
  - 4 INCOMPLETE: `mv_valid` fell before the goal was reached.
  - 5 EXTRA: a move arrived after the goal was reached.
  - 6 TIMEOUT: `WAIT_MAX` or `MAX_STEPS` exceeded.
  - 7 PROTO: `in_valid` gap mid-load, `mv_valid` during load, or `in_valid` during moves.
- States:
  - IDLE: all registers cleared. `in_valid`=1 stores cell 0 and goes to LOAD.
  - LOAD: stores cells 1..288 at the cell index. After cell 288 goes to WAIT.
    - `in_valid`=0 before cell 288 → err 7 → REPORT.
    - `mv_valid`=1 → err 7 → DRAIN.
  - WAIT: wait counter increments each cycle.
    - `mv_valid`=1 → RUN, and this first move is checked.
    - Counter reaches `WAIT_MAX` → err 6 → REPORT.
  - RUN: each `mv_valid` cycle, compute the target cell from pos and `mv`, then check in priority order:
    - OOB;
    - WALL;
    - MONSTER with sword=0;
    - EXTRA if pos was already (16,16);
    - steps = `MAX_STEPS` → TIMEOUT.
    - On error: latch err, steps not incremented, → DRAIN.
    - Otherwise: pos ← target, steps+1. Target is a sword cell → sword ← 1 and stays 1.
    - `mv_valid`=0 → err ← (pos = goal) ? 0 : 4 → REPORT.
  - DRAIN: ignores moves until `mv_valid`=0, then → REPORT.
  - REPORT: `done`=1 for one cycle; `pass` = (err = 0). Then → IDLE, which clears map, pos (0,0), sword and counters.
- Start is (0,0) and goal is (16,16). Their cell codes are not checked.
- A monster cell entered with the sword is legal and is not modified.
- Arithmetic:
  - Row and col are 5-bit, range 0..16.
  - OOB is detected before the increment/decrement, so no wrap-around is possible.
  - `steps` saturates by construction at `MAX_STEPS`.

## Timing
- Reset values: `done`=0, `pass`=0, `err`=0, `steps`=0, state IDLE.
- Reset mid-operation aborts with no `done`.
- Checks are combinational on the registered pos/sword and the map read; results are registered. This gives one move per cycle, back-to-back.
- `mv_valid` first sampled low at cycle t (in RUN or DRAIN) → REPORT at t+1 → `done`=1 at t+1 only. Outputs are registered.
- TIMEOUT from WAIT: `done` asserts the cycle after the counter reaches `WAIT_MAX`.
- `pass`/`err`/`steps` hold their values from `done` until the next load begins.
- The first move may arrive in the cycle right after cell 288.

## Structure
- Package `maze_chk_pkg`:
  - `N`;
  - cell enum (PATH, WALL, SWORD, MONSTER);
  - move enum (RIGHT, DOWN, LEFT, UP);
  - err enum (codes 0–7);
  - state enum.
- Sub-module `maze_map_store`:
  - 289×2-bit register array;
  - write port by linear index;
  - combinational read by (row, col);
  - synchronous clear.
- Top level holds the FSM, pos/sword registers, counters and move decode.

## Test plan
- All-path maze; 16 RIGHT then 16 DOWN, `mv_valid` drops → `done` 1 cycle later, `pass`=1, `err`=0, `steps`=32.
- Cell (0,1)=WALL; first move RIGHT → `err`=1, `steps`=0; `done` the cycle after `mv_valid` falls following 5 more moves.
- Cell (0,1)=MONSTER, (1,0)=SWORD; moves DOWN, UP, RIGHT, then a legal route to goal → `pass`=1. Without the sword cell: RIGHT first → `err`=2.
- First move UP → `err`=3. Ten legal moves then stop → `err`=4, `steps`=10. Reaching the goal plus one move → `err`=5.
- No `mv_valid` after load → `done` with `err`=6 at `WAIT_MAX`+1 cycles after the last cell. `in_valid` gap at cell 100 → `err`=7.
- Reset asserted mid-RUN, then a fresh all-path maze → no stale `done`; second run passes with `steps`=32.

Source files
------------

// File: rtl/maze_chk_pkg.sv
// rtl/maze_chk_pkg.sv - shared types and constants for the maze path checker
package maze_chk_pkg;

    localparam int N     = 17;
    localparam int CELLS = N * N;

    localparam logic [4:0] LAST     = 5'(N - 1);
    localparam logic [8:0] LAST_IDX = 9'(CELLS - 1);

    typedef enum logic [1:0] {
        CELL_PATH,
        CELL_WALL,
        CELL_SWORD,
        CELL_MONSTER
    } cell_t;

    typedef enum logic [1:0] {
        MV_RIGHT,
        MV_DOWN,
        MV_LEFT,
        MV_UP
    } move_t;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_WALL,
        ERR_MONSTER,
        ERR_OOB,
        ERR_INCOMPLETE,
        ERR_EXTRA,
        ERR_TIMEOUT,
        ERR_PROTO
    } err_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RUN,
        ST_DRAIN,
        ST_REPORT
    } state_t;

    function automatic logic [8:0] cell_index(input logic [4:0] row, input logic [4:0] col);
        return 9'(row * N + col);
    endfunction

endpackage

// File: rtl/maze_path_checker_if.sv
// rtl/maze_path_checker_if.sv - maze load, move stream and result signals
interface maze_path_checker_if;

    logic        in_valid;
    logic [1:0]  in;
    logic        mv_valid;
    logic [1:0]  mv;
    logic        done;
    logic        pass;
    logic [2:0]  err;
    logic [13:0] steps;

    modport master (
        output in_valid, in, mv_valid, mv,
        input  done, pass, err, steps
    );

    modport slave (
        input  in_valid, in, mv_valid, mv,
        output done, pass, err, steps
    );

endinterface

// File: rtl/maze_map_store.sv
// rtl/maze_map_store.sv - 17x17 cell map, indexed write, (row,col) read
module maze_map_store
    import maze_chk_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       we,
    input  logic [8:0] waddr,
    input  cell_t      wdata,
    input  logic [4:0] rrow,
    input  logic [4:0] rcol,
    output cell_t      rdata
);

    cell_t      cells [CELLS];
    logic [8:0] raddr;

    // A write in the same cycle as a clear wins, so cell 0 survives the IDLE clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < CELLS; i++) begin
                cells[i] <= CELL_PATH;
            end
        end
        if (we && (waddr <= LAST_IDX)) begin
            cells[waddr] <= wdata;
        end
    end

    assign raddr = cell_index(rrow, rcol);
    assign rdata = ((rrow <= LAST) && (rcol <= LAST)) ? cells[raddr] : CELL_PATH;

endmodule

// File: rtl/maze_path_checker.sv
// rtl/maze_path_checker.sv - loads a maze, replays the move stream, reports the first illegal move
module maze_path_checker
    import maze_chk_pkg::*;
#(
    parameter int WAIT_MAX  = 5000,
    parameter int MAX_STEPS = 10000
) (
    input logic                clk,
    input logic                rst_n,
    maze_path_checker_if.slave bus
);

    localparam int            WW         = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_MAX - 1);
    localparam logic [13:0]   STEP_LIMIT = 14'(MAX_STEPS);

    state_t        state;
    logic [8:0]    load_idx;
    logic [WW-1:0] wait_cnt;
    logic [4:0]    row;
    logic [4:0]    col;
    logic          sword;
    logic [13:0]   step_cnt;
    err_t          err_q;

    logic          oob;
    logic [4:0]    t_row;
    logic [4:0]    t_col;
    cell_t         t_cell;
    err_t          move_err;
    logic          at_goal;
    logic          fin;
    err_t          fin_err;
    logic          map_clr;
    logic          map_we;
    logic [8:0]    map_waddr;

    assign at_goal = (row == LAST) && (col == LAST);

    // Edge tests happen before the step, so the target never wraps.
    always_comb begin
        oob   = 1'b0;
        t_row = row;
        t_col = col;
        case (move_t'(bus.mv))
            MV_RIGHT: if (col == LAST)  oob = 1'b1; else t_col = col + 5'd1;
            MV_DOWN:  if (row == LAST)  oob = 1'b1; else t_row = row + 5'd1;
            MV_LEFT:  if (col == 5'd0)  oob = 1'b1; else t_col = col - 5'd1;
            MV_UP:    if (row == 5'd0)  oob = 1'b1; else t_row = row - 5'd1;
        endcase
    end

    always_comb begin
        move_err = ERR_NONE;
        if (oob)                                      move_err = ERR_OOB;
        else if (t_cell == CELL_WALL)                 move_err = ERR_WALL;
        else if ((t_cell == CELL_MONSTER) && !sword)  move_err = ERR_MONSTER;
        else if (at_goal)                             move_err = ERR_EXTRA;
        else if (step_cnt == STEP_LIMIT)              move_err = ERR_TIMEOUT;
    end

    // Conditions that end a run this cycle and the code to report.
    always_comb begin
        fin     = 1'b0;
        fin_err = err_q;
        case (state)
            ST_LOAD: if (!bus.mv_valid && !bus.in_valid) begin
                fin     = 1'b1;
                fin_err = ERR_PROTO;
            end
            ST_WAIT: if (!bus.mv_valid && (wait_cnt == WAIT_LAST)) begin
                fin     = 1'b1;
                fin_err = ERR_TIMEOUT;
            end
            ST_RUN: if (!bus.mv_valid) begin
                fin     = 1'b1;
                fin_err = bus.in_valid ? ERR_PROTO : (at_goal ? ERR_NONE : ERR_INCOMPLETE);
            end
            ST_DRAIN: if (!bus.mv_valid) begin
                fin = 1'b1;
            end
            default: fin = 1'b0;
        endcase
    end

    assign map_clr   = (state == ST_IDLE);
    assign map_we    = bus.in_valid && ((state == ST_IDLE) || ((state == ST_LOAD) && !bus.mv_valid));
    assign map_waddr = (state == ST_IDLE) ? 9'd0 : load_idx;

    maze_map_store u_map (
        .clk   (clk),
        .clr   (map_clr),
        .we    (map_we),
        .waddr (map_waddr),
        .wdata (cell_t'(bus.in)),
        .rrow  (t_row),
        .rcol  (t_col),
        .rdata (t_cell)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            load_idx  <= 9'd1;
            wait_cnt  <= '0;
            row       <= 5'd0;
            col       <= 5'd0;
            sword     <= 1'b0;
            step_cnt  <= 14'd0;
            err_q     <= ERR_NONE;
            bus.done  <= 1'b0;
            bus.pass  <= 1'b0;
            bus.err   <= 3'd0;
            bus.steps <= 14'd0;
        end else begin
            bus.done <= 1'b0;
            if (fin) begin
                state     <= ST_REPORT;
                err_q     <= fin_err;
                bus.done  <= 1'b1;
                bus.pass  <= (fin_err == ERR_NONE);
                bus.err   <= fin_err;
                bus.steps <= step_cnt;
            end else begin
                case (state)
                    ST_IDLE: begin
                        load_idx <= 9'd1;
                        wait_cnt <= '0;
                        row      <= 5'd0;
                        col      <= 5'd0;
                        sword    <= 1'b0;
                        step_cnt <= 14'd0;
                        err_q    <= ERR_NONE;
                        // Previous result stays visible until the next load starts.
                        if (bus.in_valid) begin
                            state     <= ST_LOAD;
                            bus.pass  <= 1'b0;
                            bus.err   <= 3'd0;
                            bus.steps <= 14'd0;
                        end
                    end
                    ST_LOAD: begin
                        if (bus.mv_valid) begin
                            err_q <= ERR_PROTO;
                            state <= ST_DRAIN;
                        end else begin
                            load_idx <= load_idx + 9'd1;
                            if (load_idx == LAST_IDX) state <= ST_WAIT;
                        end
                    end
                    ST_WAIT, ST_RUN: begin
                        if ((state == ST_RUN) && bus.in_valid) begin
                            err_q <= ERR_PROTO;
                            state <= ST_DRAIN;
                        end else if (bus.mv_valid) begin
                            if (move_err != ERR_NONE) begin
                                err_q <= move_err;
                                state <= ST_DRAIN;
                            end else begin
                                row      <= t_row;
                                col      <= t_col;
                                step_cnt <= step_cnt + 14'd1;
                                if (t_cell == CELL_SWORD) sword <= 1'b1;
                                state    <= ST_RUN;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + WW'(1);
                        end
                    end
                    ST_DRAIN:  state <= ST_DRAIN;
                    ST_REPORT: state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
